// File: rtl/gmii_tx_framer_pkg.sv
// Shared constants for the GMII transmit framer: state encoding, preamble bytes,
// CRC-32 constants and parameter defaults.
package gmii_tx_framer_pkg;

    localparam logic [5:0] ST_IDLE = 6'b000001;
    localparam logic [5:0] ST_PRE  = 6'b000010;
    localparam logic [5:0] ST_DATA = 6'b000100;
    localparam logic [5:0] ST_PAD  = 6'b001000;
    localparam logic [5:0] ST_FCS  = 6'b010000;
    localparam logic [5:0] ST_IPG  = 6'b100000;

    localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0] SFD_BYTE      = 8'hD5;

    localparam logic [31:0] CRC_POLY      = 32'h04C11DB7;
    localparam logic [31:0] CRC_POLY_REFL = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
    localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB20E3;

    localparam int IPG_MIN_DEF = 12;
    localparam int PKT_MIN_DEF = 60;
    localparam int PKT_MAX_DEF = 1514;

endpackage

// File: rtl/crc32_d8.sv
// Combinational reflected CRC-32 next state for one byte (LSB first).
// Zero latency; no flow control.
module crc32_d8
    import gmii_tx_framer_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  data,
    output logic [31:0] crc_out
);

    logic [31:0] c;

    always_comb begin
        c = crc_in ^ {24'h0, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY_REFL) : (c >> 1);
        end
    end

    assign crc_out = c;

endmodule

// File: rtl/gmii_tx_framer.sv
// Byte stream to GMII framer: preamble/SFD, min-size padding, FCS, inter-packet gap.
// Payload byte appears on GMII one cycle after acceptance; s_ready only in DATA or while dropping.
module gmii_tx_framer
    import gmii_tx_framer_pkg::*;
#(
    parameter int IPG_MIN = IPG_MIN_DEF,
    parameter int PKT_MIN = PKT_MIN_DEF,
    parameter int PKT_MAX = PKT_MAX_DEF
)(
    input  logic        gmii_tx_clk,
    input  logic        rst,
    input  logic [7:0]  s_data,
    input  logic        s_valid,
    input  logic        s_last,
    output logic        s_ready,
    output logic [7:0]  gmii_data_out,
    output logic        gmii_en_out,
    output logic [15:0] tx_len,
    output logic        frame_done,
    output logic        tx_abort
);

    logic [5:0]  state;
    logic [15:0] byte_cnt;
    logic [15:0] aux_cnt;
    logic [31:0] crc;
    logic [31:0] crc_nxt;
    logic [31:0] fcs_word;
    logic [7:0]  crc_din;
    logic        fcs_inv;
    logic        drop_pend;

    assign s_ready  = (state == ST_DATA) || drop_pend;
    assign crc_din  = (state == ST_PAD) ? 8'h00 : s_data;
    // The register holds the un-inverted CRC, so the deliberately bad FCS is the register itself.
    assign fcs_word = fcs_inv ? crc : ~crc;

    crc32_d8 u_crc32_d8 (
        .crc_in  (crc),
        .data    (crc_din),
        .crc_out (crc_nxt)
    );

    always_ff @(posedge gmii_tx_clk or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            byte_cnt      <= 16'd0;
            aux_cnt       <= 16'd0;
            crc           <= CRC_INIT;
            fcs_inv       <= 1'b0;
            drop_pend     <= 1'b0;
            gmii_data_out <= 8'h00;
            gmii_en_out   <= 1'b0;
            frame_done    <= 1'b0;
            tx_abort      <= 1'b0;
            tx_len        <= 16'd0;
        end else begin
            frame_done    <= 1'b0;
            tx_abort      <= 1'b0;
            gmii_en_out   <= 1'b0;
            gmii_data_out <= 8'h00;
            if (s_valid && s_ready && s_last && (state != ST_DATA))
                drop_pend <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (s_valid && !drop_pend) begin
                        state    <= ST_PRE;
                        aux_cnt  <= 16'd0;
                        byte_cnt <= 16'd0;
                        crc      <= CRC_INIT;
                        fcs_inv  <= 1'b0;
                    end
                end
                ST_PRE: begin
                    gmii_en_out   <= 1'b1;
                    gmii_data_out <= (aux_cnt == 16'd7) ? SFD_BYTE : PREAMBLE_BYTE;
                    aux_cnt       <= aux_cnt + 16'd1;
                    if (aux_cnt == 16'd7) begin
                        state   <= ST_DATA;
                        aux_cnt <= 16'd0;
                    end
                end
                ST_DATA: begin
                    gmii_en_out <= 1'b1;
                    if (s_valid) begin
                        gmii_data_out <= s_data;
                        crc           <= crc_nxt;
                        byte_cnt      <= byte_cnt + 16'd1;
                        if (s_last) begin
                            state <= (byte_cnt + 16'd1 < 16'(PKT_MIN)) ? ST_PAD : ST_FCS;
                        end else if (byte_cnt + 16'd1 == 16'(PKT_MAX)) begin
                            state     <= ST_FCS;
                            fcs_inv   <= 1'b1;
                            drop_pend <= 1'b1;
                            tx_abort  <= 1'b1;
                        end
                    end else begin
                        // Underrun: emit the first corrupted FCS byte now so TX_EN never gaps.
                        gmii_data_out <= crc[7:0];
                        aux_cnt       <= 16'd1;
                        state         <= ST_FCS;
                        fcs_inv       <= 1'b1;
                        drop_pend     <= 1'b1;
                        tx_abort      <= 1'b1;
                    end
                end
                ST_PAD: begin
                    gmii_en_out <= 1'b1;
                    crc         <= crc_nxt;
                    byte_cnt    <= byte_cnt + 16'd1;
                    if (byte_cnt + 16'd1 >= 16'(PKT_MIN))
                        state <= ST_FCS;
                end
                ST_FCS: begin
                    gmii_en_out   <= 1'b1;
                    gmii_data_out <= fcs_word[{aux_cnt[1:0], 3'b000} +: 8];
                    aux_cnt       <= aux_cnt + 16'd1;
                    if (aux_cnt == 16'd3) begin
                        frame_done <= 1'b1;
                        tx_len     <= byte_cnt + 16'd4;
                        state      <= ST_IPG;
                        aux_cnt    <= 16'd0;
                    end
                end
                ST_IPG: begin
                    // IDLE and the registered output stage supply the remaining low cycles.
                    aux_cnt <= aux_cnt + 16'd1;
                    if (aux_cnt + 16'd2 >= 16'(IPG_MIN)) begin
                        state   <= ST_IDLE;
                        aux_cnt <= 16'd0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gmii_tx_framer.sv
// Randomized and directed bench for gmii_tx_framer against a frame-level reference model.
module tb_gmii_tx_framer;

    localparam int IPG_MIN = 12;
    localparam int PKT_MIN = 60;
    localparam int PKT_MAX = 1514;

    logic        gmii_tx_clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  s_data = 8'h00;
    logic        s_valid = 1'b0;
    logic        s_last = 1'b0;
    logic        s_ready;
    logic [7:0]  gmii_data_out;
    logic        gmii_en_out;
    logic [15:0] tx_len;
    logic        frame_done;
    logic        tx_abort;

    gmii_tx_framer #(.IPG_MIN(IPG_MIN), .PKT_MIN(PKT_MIN), .PKT_MAX(PKT_MAX)) dut (
        .gmii_tx_clk   (gmii_tx_clk),
        .rst           (rst),
        .s_data        (s_data),
        .s_valid       (s_valid),
        .s_last        (s_last),
        .s_ready       (s_ready),
        .gmii_data_out (gmii_data_out),
        .gmii_en_out   (gmii_en_out),
        .tx_len        (tx_len),
        .frame_done    (frame_done),
        .tx_abort      (tx_abort)
    );

    always #5 gmii_tx_clk = ~gmii_tx_clk;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] pay [0:2047];
    logic [7:0] fb  [0:2047];
    logic [7:0] exp_q[$];
    int         exp_len_q[$];
    int         exp_txlen_q[$];
    int         exp_abort_q[$];

    int drv_cnt = 0;
    int disc_stalls = 0;
    bit rst_hit = 0;

    bit in_frame = 0, seen_frame = 0;
    int gap = 0, last_gap = 0, frm_bytes = 0, frm_aborts = 0, en_cyc = 0, last_en_cnt = 0;
    int last_txlen = 0;
    logic [7:0] e_byte;
    bit lst;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Bit-serial reference CRC over fb[0..n-1], final value (already complemented).
    function automatic logic [31:0] crc32_ref(input int n);
        logic [31:0] c = 32'hFFFFFFFF;
        for (int k = 0; k < n; k++) begin
            for (int b = 0; b < 8; b++) begin
                logic fbk;
                fbk = c[0] ^ fb[k][b];
                c = c >> 1;
                if (fbk) c = c ^ 32'hEDB88320;
            end
        end
        return ~c;
    endfunction

    task automatic model_frame(input int len, input int uflow, output int keep);
        int n, wn;
        bit ab;
        logic [31:0] fcs;
        if (uflow > 0)          begin n = uflow;   ab = 1; end
        else if (len > PKT_MAX) begin n = PKT_MAX; ab = 1; end
        else                    begin n = len;     ab = 0; end
        keep = n;
        for (int k = 0; k < n; k++) fb[k] = pay[k];
        wn = n;
        if (!ab) while (wn < PKT_MIN) begin fb[wn] = 8'h00; wn++; end
        fcs = crc32_ref(wn);
        if (ab) fcs = ~fcs;
        repeat (7) exp_q.push_back(8'h55);
        exp_q.push_back(8'hD5);
        for (int k = 0; k < wn; k++) exp_q.push_back(fb[k]);
        for (int k = 0; k < 4; k++) exp_q.push_back(fcs[8*k +: 8]);
        exp_len_q.push_back(wn + 12);
        exp_txlen_q.push_back(wn + 4);
        exp_abort_q.push_back(ab ? 1 : 0);
    endtask

    task automatic send_frame(input int len, input int pat, input int uflow, input int ugap, input bit hold);
        int i, wt, keep;
        bit acc, did_u;
        for (int k = 0; k < len; k++) pay[k] = (pat == 0) ? 8'(k) : 8'($urandom);
        model_frame(len, uflow, keep);
        i = 0; wt = 0; did_u = 0; disc_stalls = 0; drv_cnt = 0;
        while (i < len && !rst_hit && wt < 6000) begin
            if (uflow > 0 && i == uflow && !did_u) begin
                s_valid = 1'b0; s_last = 1'b0;
                repeat (ugap) @(posedge gmii_tx_clk);
                #1;
                did_u = 1;
            end else begin
                s_valid = 1'b1; s_data = pay[i]; s_last = (i == len - 1);
                @(negedge gmii_tx_clk);
                acc = s_ready;
                @(posedge gmii_tx_clk);
                #1;
                if (acc) begin i++; drv_cnt = i; end
                else begin wt++; if (i >= keep) disc_stalls++; end
            end
        end
        if (wt >= 6000) chk("drv_timeout", i, len);
        if (!hold || rst_hit) begin s_valid = 1'b0; s_last = 1'b0; end
    endtask

    task automatic wait_drain();
        int c = 0;
        while (exp_len_q.size() != 0 && c < 20000) begin @(negedge gmii_tx_clk); c++; end
        chk("drain", exp_len_q.size(), 0);
        repeat (3) @(negedge gmii_tx_clk);
    endtask

    task automatic rst_check(input string tag);
        chk({tag, "_en"},         gmii_en_out, 0);
        chk({tag, "_data"},       gmii_data_out, 0);
        chk({tag, "_s_ready"},    s_ready, 0);
        chk({tag, "_frame_done"}, frame_done, 0);
        chk({tag, "_tx_abort"},   tx_abort, 0);
        chk({tag, "_tx_len"},     tx_len, 0);
    endtask

    always @(negedge gmii_tx_clk) begin
        if (rst) begin
            in_frame = 0; seen_frame = 0; gap = 0; frm_bytes = 0; frm_aborts = 0; en_cyc = 0;
        end else if (gmii_en_out) begin
            if (!in_frame) begin
                if (seen_frame) chk("ipg_gap_min", (gap >= IPG_MIN), 1);
                last_gap = gap; in_frame = 1; frm_bytes = 0; frm_aborts = 0; en_cyc = 0;
            end
            en_cyc++;
            if (tx_abort) frm_aborts++;
            chk("exp_avail", (exp_q.size() != 0 && exp_len_q.size() != 0), 1);
            if (exp_q.size() != 0 && exp_len_q.size() != 0) begin
                e_byte = exp_q.pop_front();
                frm_bytes++;
                chk("wire_byte", gmii_data_out, e_byte);
                lst = (frm_bytes == exp_len_q[0]);
                chk("frame_done", frame_done, lst);
                if (lst) begin
                    chk("tx_len", tx_len, exp_txlen_q[0]);
                    chk("abort_cnt", frm_aborts, exp_abort_q[0]);
                    last_txlen = tx_len;
                    void'(exp_len_q.pop_front());
                    void'(exp_txlen_q.pop_front());
                    void'(exp_abort_q.pop_front());
                end
            end
        end else begin
            if (in_frame) begin in_frame = 0; seen_frame = 1; last_en_cnt = en_cyc; gap = 0; end
            gap++;
            chk("idle_data", gmii_data_out, 0);
            chk("idle_frame_done", frame_done, 0);
            chk("abort_outside", tx_abort, 0);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        string s;
        int len, uf, g;
        bit hold;

        // Pin the reference CRC to the published check value.
        s = "123456789";
        for (int k = 0; k < 9; k++) fb[k] = s[k];
        chk("crc_check_value", crc32_ref(9), 32'hCBF43926);

        #2 rst = 1'b1;
        #2 rst_check("reset");
        repeat (3) @(posedge gmii_tx_clk);
        @(negedge gmii_tx_clk) rst = 1'b0;
        @(posedge gmii_tx_clk); #1;

        send_frame(64, 0, 0, 0, 0);
        wait_drain();
        chk("t64_txlen", last_txlen, 68);
        chk("t64_en_cycles", last_en_cnt, 76);

        send_frame(10, 1, 0, 0, 0);
        wait_drain();
        chk("t10_txlen", last_txlen, 64);
        chk("t10_en_cycles", last_en_cnt, 72);

        send_frame(64, 1, 0, 0, 1);
        send_frame(64, 1, 0, 0, 0);
        wait_drain();
        chk("b2b_gap", last_gap, IPG_MIN);
        chk("b2b_txlen", last_txlen, 68);

        send_frame(30, 1, 20, 3, 0);
        chk("uflow_discard_stalls", disc_stalls, 0);
        wait_drain();
        chk("uflow_txlen", last_txlen, 24);
        send_frame(40, 1, 0, 0, 0);
        wait_drain();
        chk("after_uflow_txlen", last_txlen, 64);

        send_frame(1600, 1, 0, 0, 0);
        chk("oversize_discard_stalls", disc_stalls, 0);
        wait_drain();
        chk("oversize_txlen", last_txlen, 1518);

        drv_cnt = 0;
        fork
            send_frame(64, 1, 0, 0, 0);
            begin
                for (int c = 0; c < 3000 && drv_cnt < 30; c++) @(posedge gmii_tx_clk);
                chk("rst_trigger", drv_cnt, 30);
                #3;
                rst = 1'b1; rst_hit = 1;
                #1 rst_check("midframe_rst");
                repeat (2) @(negedge gmii_tx_clk);
                exp_q.delete(); exp_len_q.delete(); exp_txlen_q.delete(); exp_abort_q.delete();
                rst = 1'b0;
            end
        join
        rst_hit = 0;
        @(posedge gmii_tx_clk); #1;
        send_frame(64, 0, 0, 0, 0);
        wait_drain();
        chk("post_rst_txlen", last_txlen, 68);

        for (int f = 0; f < 30; f++) begin
            len  = ($urandom_range(0, 4) == 0) ? $urandom_range(100, 400) : $urandom_range(1, 100);
            uf   = ($urandom_range(0, 4) == 0 && len >= 2) ? $urandom_range(1, len - 1) : 0;
            hold = $urandom_range(0, 1);
            send_frame(len, 1, uf, $urandom_range(1, 3), hold);
            if (!hold) begin
                g = $urandom_range(0, 4);
                if (g > 0) begin
                    repeat (g) @(posedge gmii_tx_clk);
                    #1;
                end
            end
        end
        s_valid = 1'b0; s_last = 1'b0;
        wait_drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
